// File: rtl/column_flattener.sv
// Column flattener: expands one DDA result word per screen column into SCREEN_HEIGHT frame-buffer beats.
// Latency: first beat is valid the cycle after the FIFO handshake; one beat per cycle; column period >= SCREEN_HEIGHT+1.
// Backpressure: beats hold while fb_ready_in is low; FIFO is not accepted until the column finishes. Optional: COLUMN_FLATTENER_SHADE_EN.
module column_flattener #(
  parameter int                     SCREEN_WIDTH  = 320,
  parameter int                     SCREEN_HEIGHT = 180,
  parameter int                     PIXEL_WIDTH   = 16,
  parameter int                     HCOUNT_WIDTH  = 9,
  parameter int                     LH_WIDTH      = 8,
  parameter int                     ADDR_WIDTH    = 16,
  parameter logic [PIXEL_WIDTH-1:0] CEILING_COLOR = 16'h0000,
  parameter logic [PIXEL_WIDTH-1:0] FLOOR_COLOR   = 16'h8410
) (
  input  logic                                 pixel_clk_in,
  input  logic                                 rst_n_in,
  input  logic                                 dda_fifo_tvalid_in,
  input  logic [HCOUNT_WIDTH+LH_WIDTH+22-1:0]  dda_fifo_tdata_in,
  output logic                                 transformer_tready,
  input  logic                                 fb_ready_in,
  output logic                                 ray_valid_out,
  output logic [ADDR_WIDTH-1:0]                ray_address_out,
  output logic [PIXEL_WIDTH-1:0]               ray_pixel_out,
  output logic                                 ray_last_pixel_out,
  output logic                                 col_drop_err_out
);

  // Row counter wide enough to hold SCREEN_HEIGHT itself (draw_end may equal it).
  localparam int RW = $clog2(SCREEN_HEIGHT + 1);
  // Signed working width for the draw-range arithmetic; two spare bits cover sign and carry.
  localparam int CW = ((LH_WIDTH > RW) ? LH_WIDTH : RW) + 2;

  localparam logic signed [CW-1:0] MID_S     = CW'(SCREEN_HEIGHT / 2);
  localparam logic signed [CW-1:0] HGT_S     = CW'(SCREEN_HEIGHT);
  localparam logic [RW-1:0]        LAST_ROW  = RW'(SCREEN_HEIGHT - 1);
  localparam logic [RW-1:0]        HGT_ROW   = RW'(SCREEN_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(SCREEN_WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  // Incoming word fields, MSB first.
  logic [HCOUNT_WIDTH-1:0] in_hcount;
  logic [LH_WIDTH-1:0]     in_lh;
  logic                    in_wt;
  logic [3:0]              in_map;
  logic [15:0]             in_wallx;
  logic                    in_tlast;

  assign {in_hcount, in_lh, in_wt, in_map, in_wallx, in_tlast} = dda_fifo_tdata_in;

  logic [0:0]             state_q,  state_d;
  logic [RW-1:0]          row_q,    row_d;
  logic [RW-1:0]          ds_q,     ds_d;
  logic [RW-1:0]          de_q,     de_d;
  logic [3:0]             map_q,    map_d;
  logic                   wt_q,     wt_d;
  logic [15:0]            wallx_q,  wallx_d;
  logic                   tlast_q,  tlast_d;
  logic                   valid_q,  valid_d;
  logic [ADDR_WIDTH-1:0]  addr_q,   addr_d;
  logic [PIXEL_WIDTH-1:0] pixel_q,  pixel_d;
  logic                   last_q,   last_d;
  logic                   tready_q, tready_d;
  logic                   drop_q,   drop_d;

  logic signed [CW-1:0]   half_s;
  logic signed [CW-1:0]   start_s;
  logic signed [CW-1:0]   end_s;
  logic [RW-1:0]          cand_start;
  logic [RW-1:0]          cand_end;
  logic [RW-1:0]          row_inc;
  logic                   hcount_oob;
  logic                   shade_in;
  logic                   shade_lat;

  assign row_inc    = row_q + RW'(1);
  assign hcount_oob = (32'(in_hcount) >= SCREEN_WIDTH);

`ifdef COLUMN_FLATTENER_SHADE_EN
  assign shade_in  = in_wt;
  assign shade_lat = wt_q;
`else
  assign shade_in  = 1'b0;
  assign shade_lat = 1'b0;
`endif

  // wallX (and wallType in the plain build) are carried for a future texture stage.
  logic unused_fields;
  assign unused_fields = ^{wallx_q, wt_q};

  // Colour for one row given the column's draw range and map value.
  function automatic logic [PIXEL_WIDTH-1:0] pick_pixel(
    input logic [RW-1:0] row,
    input logic [RW-1:0] ds,
    input logic [RW-1:0] de,
    input logic [3:0]    m,
    input logic          shade
  );
    logic [15:0] pal;
    pal = {m, 1'b1, m, 2'b11, ~m, 1'b1};
    if (shade) begin
      pal = {1'b0, pal[15:12], 1'b0, pal[10:6], 1'b0, pal[4:1]};
    end
    if (row < ds) begin
      pick_pixel = CEILING_COLOR;
    end else if (row >= de) begin
      pick_pixel = FLOOR_COLOR;
    end else if (m == 4'd0) begin
      pick_pixel = FLOOR_COLOR;
    end else begin
      pick_pixel = PIXEL_WIDTH'(pal);
    end
  endfunction

  // Draw range for the word on the FIFO port, clamped to [0, SCREEN_HEIGHT].
  always_comb begin
    half_s     = $signed({{(CW - LH_WIDTH + 1){1'b0}}, in_lh[LH_WIDTH-1:1]});
    start_s    = MID_S - half_s;
    end_s      = MID_S + half_s;
    cand_start = start_s[CW-1] ? '0 : start_s[RW-1:0];
    cand_end   = (end_s > HGT_S) ? HGT_ROW : end_s[RW-1:0];
  end

  // Column FSM: latch a word in IDLE, then walk rows with an incremental address.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    ds_d     = ds_q;
    de_d     = de_q;
    map_d    = map_q;
    wt_d     = wt_q;
    wallx_d  = wallx_q;
    tlast_d  = tlast_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    pixel_d  = pixel_q;
    last_d   = last_q;
    tready_d = tready_q;
    drop_d   = drop_q;

    case (state_q)
      IDLE: begin
        tready_d = 1'b1;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        if (dda_fifo_tvalid_in && tready_q) begin
          if (hcount_oob) begin
            // Out-of-range column: swallow it and flag it until reset.
            drop_d = 1'b1;
          end else begin
            state_d  = EMIT;
            tready_d = 1'b0;
            row_d    = '0;
            ds_d     = cand_start;
            de_d     = cand_end;
            map_d    = in_map;
            wt_d     = in_wt;
            wallx_d  = in_wallx;
            tlast_d  = in_tlast;
            valid_d  = 1'b1;
            addr_d   = ADDR_WIDTH'(in_hcount);
            pixel_d  = pick_pixel('0, cand_start, cand_end, in_map, shade_in);
            last_d   = in_tlast && (LAST_ROW == '0);
          end
        end
      end
      EMIT: begin
        if (valid_q && fb_ready_in) begin
          if (row_q == LAST_ROW) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            tready_d = 1'b1;
          end else begin
            // Row base advances by one screen line per beat; no multiplier needed.
            row_d   = row_inc;
            addr_d  = addr_q + ADDR_STEP;
            pixel_d = pick_pixel(row_inc, ds_q, de_q, map_q, shade_lat);
            last_d  = tlast_q && (row_inc == LAST_ROW);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any column in flight.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      row_q    <= '0;
      ds_q     <= '0;
      de_q     <= '0;
      map_q    <= '0;
      wt_q     <= 1'b0;
      wallx_q  <= '0;
      tlast_q  <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      pixel_q  <= '0;
      last_q   <= 1'b0;
      tready_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      ds_q     <= ds_d;
      de_q     <= de_d;
      map_q    <= map_d;
      wt_q     <= wt_d;
      wallx_q  <= wallx_d;
      tlast_q  <= tlast_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      pixel_q  <= pixel_d;
      last_q   <= last_d;
      tready_q <= tready_d;
      drop_q   <= drop_d;
    end
  end

  assign transformer_tready = tready_q;
  assign ray_valid_out      = valid_q;
  assign ray_address_out    = addr_q;
  assign ray_pixel_out      = pixel_q;
  assign ray_last_pixel_out = last_q;
  assign col_drop_err_out   = drop_q;

endmodule

// File: tb/tb_column_flattener.sv
// Directed bench for column_flattener: reset, wall/ceiling/floor rows, clamping, backpressure, last pixel, drop, mid-column reset.
// Timing: inputs driven and outputs sampled 1ns after the rising edge.
// Backpressure: fb_ready pattern 1,0,0,1 in one scenario.
module tb_column_flattener;

  localparam logic [15:0] CEIL  = 16'h0000;
  localparam logic [15:0] FLOOR = 16'h8410;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tvalid;
  logic [38:0] tdata;
  logic        tready;
  logic        fb_ready;
  logic        valid;
  logic [15:0] addr;
  logic [15:0] pixel;
  logic        last;
  logic        drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  column_flattener dut (
    .pixel_clk_in       (clk),
    .rst_n_in           (rst_n),
    .dda_fifo_tvalid_in (tvalid),
    .dda_fifo_tdata_in  (tdata),
    .transformer_tready (tready),
    .fb_ready_in        (fb_ready),
    .ray_valid_out      (valid),
    .ray_address_out    (addr),
    .ray_pixel_out      (pixel),
    .ray_last_pixel_out (last),
    .col_drop_err_out   (drop)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word and follow its column; stop_row >= 0 returns while that row is presented.
  task automatic run_column(input string name, input logic [8:0] hc, input logic [7:0] lh,
                            input logic wt, input logic [3:0] m, input logic tl,
                            input int exp_start, input int exp_end, input logic [15:0] exp_wall,
                            input bit bp, input int stop_row);
    int          n;
    int          cyc;
    int          row;
    bit          stalled;
    logic [15:0] sv_addr;
    logic [15:0] sv_pix;
    logic [3:0]  pat;
    logic [15:0] exp_pix;
    logic [15:0] exp_addr;
    logic        exp_last;
    pat      = 4'b1001;
    tvalid   = 1'b1;
    tdata    = {hc, lh, wt, m, 16'hA5A5, tl};
    fb_ready = 1'b1;
    n = 0;
    while (tready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (tready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: tready got %b want 1", name, tready);
      tvalid = 1'b0;
      return;
    end
    tick();
    tvalid  = 1'b0;
    cyc     = 1;
    row     = 0;
    stalled = 1'b0;
    sv_addr = '0;
    sv_pix  = '0;
    while (row < 180 && cyc < 1000) begin
      fb_ready = bp ? pat[cyc % 4] : 1'b1;
      checks++;
      if (valid !== 1'b1 || tready !== 1'b0) begin
        errors++;
        $display("FAIL %s emit flags row %0d: valid/tready got %b%b want 10", name, row, valid, tready);
      end
      if (stalled) begin
        checks++;
        if (addr !== sv_addr || pixel !== sv_pix) begin
          errors++;
          $display("FAIL %s stall hold row %0d: got %h/%h want %h/%h", name, row, addr, pixel, sv_addr, sv_pix);
        end
      end
      if (stop_row == row) return;
      if (valid === 1'b1 && fb_ready) begin
        exp_addr = 16'(hc + row * 320);
        exp_pix  = (row < exp_start) ? CEIL : (row >= exp_end) ? FLOOR : exp_wall;
        exp_last = tl && (row == 179);
        checks++;
        if (addr !== exp_addr) begin
          errors++;
          $display("FAIL %s addr row %0d: got %0d want %0d", name, row, addr, exp_addr);
        end
        checks++;
        if (pixel !== exp_pix) begin
          errors++;
          $display("FAIL %s pixel row %0d: got %h want %h", name, row, pixel, exp_pix);
        end
        checks++;
        if (last !== exp_last) begin
          errors++;
          $display("FAIL %s last row %0d: got %b want %b", name, row, last, exp_last);
        end
        row++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        sv_addr = addr;
        sv_pix  = pixel;
      end
      tick();
      cyc++;
    end
    fb_ready = 1'b1;
    checks++;
    if (row != 180) begin
      errors++;
      $display("FAIL %s beat count: got %0d want 180", name, row);
    end
    if (!bp) begin
      checks++;
      if (cyc != 181) begin
        errors++;
        $display("FAIL %s column period: got %0d want 181", name, cyc);
      end
    end
    checks++;
    if (valid !== 1'b0 || tready !== 1'b1 || last !== 1'b0) begin
      errors++;
      $display("FAIL %s end flags: valid/tready/last got %b%b%b want 010", name, valid, tready, last);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (valid !== 1'b0 || tready !== 1'b0 || last !== 1'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: v/r/l/d got %b%b%b%b want 0000", valid, tready, last, drop);
    end
    checks++;
    if (addr !== 16'h0 || pixel !== 16'h0) begin
      errors++;
      $display("FAIL reset data: got %h/%h want 0000/0000", addr, pixel);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (tready !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset release: tready/valid got %b%b want 10", tready, valid);
    end
  endtask

  // lineHeight 60 -> rows 60..119 wall; mapData 1 -> R 00011 G 000111 B 11101 = 18FD.
  task automatic test_basic();
    run_column("basic", 9'd5, 8'd60, 1'b0, 4'd1, 1'b0, 60, 120, 16'h18FD, 1'b0, -1);
  endtask

  // lineHeight 255 clamps to the whole column; mapData 2 -> 297B.
  task automatic test_clamp();
    run_column("clamp", 9'd7, 8'd255, 1'b0, 4'd2, 1'b0, 0, 180, 16'h297B, 1'b0, -1);
  endtask

  // lineHeight 100 -> rows 40..139 wall; mapData 15 -> FFE1.
  task automatic test_backpressure();
    run_column("backpressure", 9'd100, 8'd100, 1'b0, 4'd15, 1'b0, 40, 140, 16'hFFE1, 1'b1, -1);
  endtask

  // lineHeight 0 -> no wall rows; last flag only on address 57599.
  task automatic test_last_pixel();
    run_column("last", 9'd319, 8'd0, 1'b0, 4'd3, 1'b1, 90, 90, 16'h0000, 1'b0, -1);
  endtask

  task automatic test_drop();
    tvalid = 1'b1;
    tdata  = {9'd320, 8'd60, 1'b0, 4'd1, 16'h1234, 1'b0};
    tick();
    tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (valid !== 1'b0 || tready !== 1'b1) begin
        errors++;
        $display("FAIL drop idle cycle %0d: valid/tready got %b%b want 01", i, valid, tready);
      end
      tick();
    end
    checks++;
    if (drop !== 1'b1) begin
      errors++;
      $display("FAIL drop flag: got %b want 1", drop);
    end
    // mapData 0 inside the wall range is floor; rows 89..90 are the wall span.
    run_column("after_drop", 9'd0, 8'd2, 1'b0, 4'd0, 1'b0, 89, 91, FLOOR, 1'b0, -1);
    checks++;
    if (drop !== 1'b1) begin
      errors++;
      $display("FAIL drop sticky: got %b want 1", drop);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] wall;
`ifdef COLUMN_FLATTENER_SHADE_EN
    wall = 16'h086E;
`else
    wall = 16'h18FD;
`endif
    run_column("pre_reset", 9'd10, 8'd180, 1'b1, 4'd1, 1'b1, 0, 180, wall, 1'b0, 90);
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || tready !== 1'b0 || last !== 1'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL mid reset flags: v/r/l/d got %b%b%b%b want 0000", valid, tready, last, drop);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (tready !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid reset release: tready/valid got %b%b want 10", tready, valid);
    end
    run_column("post_reset", 9'd10, 8'd180, 1'b1, 4'd1, 1'b1, 0, 180, wall, 1'b0, -1);
  endtask

  initial begin
    rst_n    = 1'b0;
    tvalid   = 1'b0;
    tdata    = '0;
    fb_ready = 1'b0;
    test_reset();
    test_basic();
    test_clamp();
    test_backpressure();
    test_last_pixel();
    test_drop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
